cruiser_motion: RTL and testbench
=================================

CRUISER_MOTION -- requirements
Module: cruiser_motion

Interface
REQ-001 SHALL have parameter W, default 7: position width per axis; field spans 0 .. 2^W-1.
REQ-002 SHALL have parameter VW, default 3: speed magnitude width; VMAX = 2^VW-1.
REQ-003 SHALL have parameter ACCEL_DIV, default 4: held-key enable ticks per speed increment; legal range >= 2.
REQ-004 SHALL have parameter HOME_X, default 2^(W-1): x reset position.
REQ-005 SHALL have parameter HOME_Y, default 2^(W-1): y reset position.
REQ-006 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-008 SHALL have port enable, input, 1 bit: frame tick; one motion step per high cycle.
REQ-009 SHALL have ports up, down, left, right, input, 1 bit each: direction keys, level-sensitive.
REQ-010 SHALL have ports cruiserx, cruisery, output, W bits each: registered positions.
REQ-011 SHALL have ports velx, vely, output, VW+1 bits each: registered two's-complement velocities.
REQ-012 SHALL have port bump, output, 1 bit: registered one-cycle pulse on edge event.
REQ-013 SHALL have port moving, output, 1 bit: high when velx or vely is nonzero.

Function
REQ-014 Per-axis direction dir SHALL be: +1 if only right/down is high; -1 if only left/up is high; 0 if neither or both are high.
REQ-015 Axes SHALL be independent, each with its own velocity and accel counter (width ceil(log2(ACCEL_DIV))).
REQ-016 On enable with dir!=0 and vel of opposite sign: vel SHALL become 0 (brake) and the counter SHALL clear.
REQ-017 On enable with dir!=0 and vel==0: vel SHALL become dir and the counter SHALL clear.
REQ-018 On enable with dir matching the sign of vel: if counter==ACCEL_DIV-1, |vel| SHALL increment (saturating at VMAX) and the counter SHALL clear; else the counter SHALL increment.
REQ-019 On enable with dir==0: vel SHALL step one toward 0 and the counter SHALL clear.
REQ-020 Position SHALL update in the same enable cycle using the new vel: pos_next = pos + vel_next, computed at W+1 signed width.
REQ-021 Cycles with enable low SHALL hold positions, velocities and counters, and SHALL drive bump to 0.
REQ-022 bump SHALL be high for exactly the clock following any enable cycle in which either axis hit an edge event (REQ-025/026).
REQ-023 moving SHALL reflect the registered velocities with zero added latency.

Reset
REQ-024 While reset is high at a clock edge: cruiserx=HOME_X, cruisery=HOME_Y, velx=vely=0, counters=0, bump=0, moving=0; reset SHALL override enable and keys and SHALL be honoured mid-motion.

Configuration
REQ-025 Without CRUISER_WRAP_EN: pos_next outside [0, 2^W-1] SHALL clamp to the violated bound, that axis's vel SHALL be forced to 0, and an edge event SHALL flag; pushing into a wall SHALL clamp and flag on every enable.
REQ-026 With CRUISER_WRAP_EN defined: pos_next SHALL wrap modulo 2^W, vel SHALL be kept, and an edge event SHALL flag whenever wrap occurs.

Verification (W=7, VW=3, ACCEL_DIV=4, home 64/64)
REQ-027 Reset, then right held for 1 enable -> velx=1, cruiserx=65, moving=1, bump=0.
REQ-028 Right held for 5 enables from reset -> velx=1,1,1,1,2; cruiserx=65,66,67,68,70.
REQ-029 From velx=2, keys released for 3 enables -> velx=1,0,0; cruiserx=71,71,71; moving drops after the second enable.
REQ-030 From velx=+2, left held for 2 enables -> velx=0 with x unchanged, then velx=-1 with x-1; left+right together -> decelerate as released.
REQ-031 Right held until edge, default build -> cruiserx=127, velx=0, bump=1 for one clock per enable; with CRUISER_WRAP_EN -> cruiserx wraps past 127 to a low value, velx kept, bump=1 for one clock.
REQ-032 Reset asserted for one clock mid-motion with enable low -> next clock cruiserx=64, cruisery=64, velx=vely=0, bump=0.

Source files
------------

// File: rtl/cruiser_motion.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cruiser_motion
// Purpose  : Two-axis cruiser with per-axis velocity, key-driven acceleration,
//            braking and friction; optional edge wrap via CRUISER_WRAP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module cruiser_motion #(
    parameter int W         = 7,
    parameter int VW        = 3,
    parameter int ACCEL_DIV = 4,
    parameter int HOME_X    = 2 ** (W - 1),
    parameter int HOME_Y    = 2 ** (W - 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    output logic [W-1:0]  cruiserx,
    output logic [W-1:0]  cruisery,
    output logic [VW:0]   velx,
    output logic [VW:0]   vely,
    output logic          bump,
    output logic          moving
);

    localparam int            CW       = $clog2(ACCEL_DIV);
    localparam logic [VW-1:0] VMAX     = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCEL_DIV - 1);

    // Index 0 is the x axis (right positive), index 1 the y axis (down positive).
    logic [1:0] key_pos;
    logic [1:0] key_neg;
    logic       bump_q;

    assign key_pos = {down, right};
    assign key_neg = {up, left};

    for (genvar i = 0; i < 2; i++) begin : g_axis
        localparam logic [W-1:0] HOME = (i == 0) ? W'(HOME_X) : W'(HOME_Y);

        logic [W-1:0]  pos_q, pos_d;
        logic [VW:0]   vel_q, vel_d, vel_n;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          dpos, dneg, vneg, vzero, hit;
        logic [VW-1:0] mag, mag_inc;
        logic [W:0]    sum;

        always_comb begin
            dpos    = key_pos[i] & ~key_neg[i];
            dneg    = key_neg[i] & ~key_pos[i];
            vneg    = vel_q[VW];
            vzero   = (vel_q == '0);
            mag     = vneg ? (~vel_q[VW-1:0] + 1'b1) : vel_q[VW-1:0];
            mag_inc = (mag == VMAX) ? mag : mag + 1'b1;
            vel_n   = vel_q;
            cnt_d   = cnt_q;
            hit     = 1'b0;

            if (dpos | dneg) begin
                if (vzero) begin
                    vel_n = dpos ? (VW+1)'(1) : '1;
                    cnt_d = '0;
                end else if (dpos == vneg) begin
                    vel_n = '0;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    vel_n = vneg ? -{1'b0, mag_inc} : {1'b0, mag_inc};
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
                if (vneg) begin
                    vel_n = vel_q + 1'b1;
                end else if (!vzero) begin
                    vel_n = vel_q - 1'b1;
                end
            end

            // Speed is far below the field size, so bit W alone marks leaving
            // the field; the sign of the velocity tells which bound was crossed.
            sum   = {1'b0, pos_q} + {{(W-VW){vel_n[VW]}}, vel_n};
            vel_d = vel_n;
`ifdef CRUISER_WRAP_EN
            pos_d = sum[W-1:0];
            hit   = sum[W];
`else
            pos_d = sum[W-1:0];
            if (sum[W]) begin
                pos_d = vel_n[VW] ? '0 : '1;
                vel_d = '0;
                hit   = 1'b1;
            end
`endif
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                pos_q <= HOME;
                vel_q <= '0;
                cnt_q <= '0;
            end else if (enable) begin
                pos_q <= pos_d;
                vel_q <= vel_d;
                cnt_q <= cnt_d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bump_q <= 1'b0;
        end else begin
            bump_q <= enable & (g_axis[0].hit | g_axis[1].hit);
        end
    end

    assign cruiserx = g_axis[0].pos_q;
    assign cruisery = g_axis[1].pos_q;
    assign velx     = g_axis[0].vel_q;
    assign vely     = g_axis[1].vel_q;
    assign bump     = bump_q;
    assign moving   = (g_axis[0].vel_q != '0) | (g_axis[1].vel_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_cruiser_motion.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : tb_cruiser_motion
// Purpose  : Scoreboard bench for cruiser_motion (W=7, VW=3, ACCEL_DIV=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cruiser_motion;

    localparam logic [3:0] KN = 4'b0000;
    localparam logic [3:0] KR = 4'b0001;
    localparam logic [3:0] KL = 4'b0010;
    localparam logic [3:0] KD = 4'b0100;
    localparam logic [3:0] KU = 4'b1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [6:0] cruiserx, cruisery;
    logic [3:0] velx, vely;
    logic       bump, moving;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int step_id = 0;

    typedef struct {
        int id;
        int due;
        int x, y, vx, vy, b, m;
    } exp_t;

    exp_t q[$];

    int XS[20] = '{65, 66, 67, 68, 70, 72, 74, 76, 79, 82,
                   85, 88, 92, 96, 100, 104, 109, 114, 119, 124};
    int VS[20] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3,
                   3, 3, 4, 4, 4, 4, 5, 5, 5, 5};

    cruiser_motion #(
        .W(7), .VW(3), .ACCEL_DIV(4), .HOME_X(64), .HOME_Y(64)
    ) dut (
        .clock   (clk),
        .reset   (reset),
        .enable  (enable),
        .up      (up),
        .down    (down),
        .left    (left),
        .right   (right),
        .cruiserx(cruiserx),
        .cruisery(cruisery),
        .velx    (velx),
        .vely    (vely),
        .bump    (bump),
        .moving  (moving)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int id, input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL step%0d %s: got %0d expected %0d", id, name, act, expv);
        end
    endtask

    // Drive one cycle of inputs; the response is due after the following edge.
    task automatic step(input logic en, input logic rs, input logic [3:0] k,
                        input int ex, input int ey, input int evx, input int evy,
                        input int eb, input int em);
        exp_t e;
        @(posedge clk);
        #1;
        enable = en;
        reset  = rs;
        {up, down, left, right} = k;
        step_id++;
        e.id = step_id; e.due = cyc + 1;
        e.x = ex; e.y = ey; e.vx = evx; e.vy = evy; e.b = eb; e.m = em;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            if (q[0].due == cyc) begin
                e = q.pop_front();
                chk(e.id, "cruiserx", int'(cruiserx), e.x);
                chk(e.id, "cruisery", int'(cruisery), e.y);
                chk(e.id, "velx", int'($signed(velx)), e.vx);
                chk(e.id, "vely", int'($signed(vely)), e.vy);
                chk(e.id, "bump", int'(bump), e.b);
                chk(e.id, "moving", int'(moving), e.m);
            end else if (q[0].due < cyc) begin
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL step%0d missed: sampled cycle %0d expected cycle %0d", e.id, cyc, e.due);
            end
        end
    end

    initial begin
        step(0, 1, KN, 64, 64, 0, 0, 0, 0);
        // Right held: start at 1, accelerate on the fourth held tick after that.
        step(1, 0, KR, 65, 64, 1, 0, 0, 1);
        step(1, 0, KR, 66, 64, 1, 0, 0, 1);
        step(1, 0, KR, 67, 64, 1, 0, 0, 1);
        step(1, 0, KR, 68, 64, 1, 0, 0, 1);
        step(1, 0, KR, 70, 64, 2, 0, 0, 1);
        step(0, 0, KR, 70, 64, 2, 0, 0, 1);
        // Friction on release.
        step(1, 0, KN, 71, 64, 1, 0, 0, 1);
        step(1, 0, KN, 71, 64, 0, 0, 0, 0);
        step(1, 0, KN, 71, 64, 0, 0, 0, 0);
        // Back up to +2, then brake and reverse.
        step(1, 0, KR, 72, 64, 1, 0, 0, 1);
        step(1, 0, KR, 73, 64, 1, 0, 0, 1);
        step(1, 0, KR, 74, 64, 1, 0, 0, 1);
        step(1, 0, KR, 75, 64, 1, 0, 0, 1);
        step(1, 0, KR, 77, 64, 2, 0, 0, 1);
        step(1, 0, KL, 77, 64, 0, 0, 0, 0);
        step(1, 0, KL, 76, 64, -1, 0, 0, 1);
        step(1, 0, KL | KR, 76, 64, 0, 0, 0, 0);
        // Y axis independence.
        step(1, 0, KD, 76, 65, 0, 1, 0, 1);
        step(1, 0, KU | KD, 76, 65, 0, 0, 0, 0);
        step(1, 0, KU, 76, 64, 0, -1, 0, 1);
        // Run into the right edge from home.
        step(0, 1, KN, 64, 64, 0, 0, 0, 0);
        for (int n = 0; n < 20; n++) begin
            step(1, 0, KR, XS[n], 64, VS[n], 0, 0, 1);
        end
`ifdef CRUISER_WRAP_EN
        step(1, 0, KR, 2, 64, 6, 0, 1, 1);
        step(1, 0, KR, 8, 64, 6, 0, 0, 1);
        step(0, 0, KR, 8, 64, 6, 0, 0, 1);
        step(1, 0, KL, 8, 64, 0, 0, 0, 0);
`else
        step(1, 0, KR, 127, 64, 0, 0, 1, 0);
        step(1, 0, KR, 127, 64, 0, 0, 1, 0);
        step(0, 0, KR, 127, 64, 0, 0, 0, 0);
        step(1, 0, KL, 126, 64, -1, 0, 0, 1);
`endif
        // Reset mid-motion with enable low and a key held.
        step(0, 1, KR, 64, 64, 0, 0, 0, 0);
        step(1, 0, KR, 65, 64, 1, 0, 0, 1);
        step(0, 0, KN, 65, 64, 1, 0, 0, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
